// File: rtl/clk_tick_defs.sv
// Shared definitions for the clk_tick_timer slow time base: FSM state encodings
// and the saturating wrap-counter width and limit.
package clk_tick_defs;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   localparam int                WRAP_W   = 8;
   localparam logic [WRAP_W-1:0] WRAP_SAT = 8'd255;

   // Increment that sticks at WRAP_SAT instead of rolling over.
   function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
      if (v == WRAP_SAT) begin
         sat_inc = v;
      end else begin
         sat_inc = v + 8'd1;
      end
   endfunction

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector for the divided clock level, treated purely as data.
// With CLK_TICK_SYNC_EN defined, ck_in first passes a two-flop synchroniser.
module edge_rise_det (
   input  logic clk,
   input  logic rst,
   input  logic i_ck_in,
   output logic o_tick
);

   logic w_ck_s;
   logic r_ck_d;

`ifdef CLK_TICK_SYNC_EN
   logic r_sync1;
   logic r_sync2;

   // Synchroniser flops reset high so a high ck_in at release is not a rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_ck_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_ck_s = r_sync2;
`else
   assign w_ck_s = i_ck_in;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ck_d <= 1'b1;
      end else begin
         r_ck_d <= w_ck_s;
      end
   end

   assign o_tick = w_ck_s & ~r_ck_d;

endmodule

// File: rtl/clk_tick_timer.sv
// Slow time base: counts rising edges of the divided clock modulo CNT_MAX+1
// under start/stop/clear control. Optional macro: CLK_TICK_SYNC_EN.
module clk_tick_timer
   import clk_tick_defs::*;
#(
   parameter int CNT_MAX = 9,
   parameter int CNT_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ck_in,
   input  logic              start,
   input  logic              stop,
   input  logic              clear,
   output logic [CNT_W-1:0]  count,
   output logic              tc_pulse,
   output logic              running,
   output logic [WRAP_W-1:0] wrap_cnt
);

   state_t              r_state;
   state_t              w_next;
   logic [CNT_W-1:0]    r_count;
   logic                r_tc_pulse;
   logic                r_running;
   logic [WRAP_W-1:0]   r_wrap_cnt;
   logic                w_tick;
   logic                w_inc;
   logic                w_wrap;

   edge_rise_det u_edge (
      .clk     (clk),
      .rst     (rst),
      .i_ck_in (ck_in),
      .o_tick  (w_tick)
   );

   // Ticks coinciding with stop/clear, or arriving before RUN is entered, are dropped.
   assign w_inc  = (r_state == ST_RUN) & w_tick & ~stop & ~clear;
   assign w_wrap = w_inc & (r_count == CNT_W'(CNT_MAX));

   // Next-state logic; priority clear > stop > start.
   always_comb begin
      w_next = r_state;
      if (clear) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_PAUSE: begin
               if (!stop && start) begin
                  w_next = ST_RUN;
               end else begin
                  w_next = r_state;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  w_next = ST_PAUSE;
               end else begin
                  w_next = ST_RUN;
               end
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   // State register and registered running flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_running <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_running <= (w_next == ST_RUN);
      end
   end

   // Tick counter, wrap pulse and saturating wrap count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count    <= '0;
         r_tc_pulse <= 1'b0;
         r_wrap_cnt <= '0;
      end else begin
         r_tc_pulse <= w_wrap;
         if (clear) begin
            r_count    <= '0;
            r_wrap_cnt <= '0;
         end else if (w_wrap) begin
            r_count    <= '0;
            r_wrap_cnt <= sat_inc(r_wrap_cnt);
         end else if (w_inc) begin
            r_count    <= r_count + CNT_W'(1);
            r_wrap_cnt <= r_wrap_cnt;
         end else begin
            r_count    <= r_count;
            r_wrap_cnt <= r_wrap_cnt;
         end
      end
   end

   assign count    = r_count;
   assign tc_pulse = r_tc_pulse;
   assign running  = r_running;
   assign wrap_cnt = r_wrap_cnt;

endmodule

// File: doc/clk_tick_timer.md
Name: clk_tick_timer

Overview:
- Downstream consumer of the Clk_divide_by_count output.
- Samples the divided clock level in the system clock domain and turns each rising edge into a one-cycle tick.
- Counts ticks in a modulo-(CNT_MAX+1) counter under start/stop/clear control.
- Flags every wrap and keeps a saturating wrap count. This is the team's basic slow-time base (seconds/digit counter) fed from the divider.

Parameters:
- CNT_MAX, 9, terminal count value; count runs 0..CNT_MAX.
- CNT_W, 4, width of count; must satisfy 2^CNT_W > CNT_MAX.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ck_in  in  1  divided clock level (Ck_out of the divider); treated as data, never used as a clock.
- start  in  1  level; request to run.
- stop  in  1  level; request to pause.
- clear  in  1  level; return to idle and zero the counters.
- count  out  CNT_W  current tick count.
- tc_pulse  out  1  one-cycle pulse on wrap CNT_MAX->0.
- running  out  1  high while in RUN.
- wrap_cnt  out  8  number of wraps since clear/reset, saturating at 255.

Behaviour:
- Single clock domain; clock and reset are fixed as above: one clock, reset synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - state=IDLE, count=0, tc_pulse=0, running=0, wrap_cnt=0.
  - ck_d=1, so a high ck_in at reset release gives no spurious tick.
- Edge detect: ck_d <= ck_s every cycle; tick = ck_s & ~ck_d (combinational). ck_s = ck_in, or the synchronised copy (see Optional Feature).
- FSM states: IDLE, RUN, PAUSE. Control priority each cycle is clear > stop > start.
  - IDLE: start -> RUN. Stop alone is ignored.
  - RUN: stop -> PAUSE.
  - PAUSE: start -> RUN.
  - Any state: clear -> IDLE, with count=0 and wrap_cnt=0 on that edge.
- Increment rule: count updates at an edge only when state==RUN, tick=1, stop=0 and clear=0.
  - Latency: count changes at the clk edge where the sampled ck_s rise is first seen (1 cycle after ck_in goes high, no synchroniser).
- Simultaneous events:
  - A tick in the same cycle as stop or clear is dropped.
  - A tick in the same cycle as start from IDLE or PAUSE is dropped; counting begins the following cycle.
- Wrap: tick with count==CNT_MAX gives, on the same edge:
  - count=0;
  - tc_pulse=1 for exactly one cycle, otherwise 0;
  - wrap_cnt+1, held at 255 once reached (no rollover).
- running is registered and equals (next state == RUN).
- In PAUSE, count and wrap_cnt hold; ck_d keeps tracking ck_s, so a rise during PAUSE is lost and never replayed.
- Reset or clear mid-run aborts immediately; no pending tick is kept.
- Constant ck_in (divider held in reset) produces no ticks; all counters hold.

Optional Feature:
- Macro CLK_TICK_SYNC_EN.
- When defined: ck_in passes through a two-flop synchroniser (both flops reset to 1) before edge detection. Tick-to-count latency becomes 3 cycles. Used when ck_in comes from an unrelated or asynchronous source.
- When undefined: ck_s = ck_in directly, latency 1 cycle. Legal only when the divider runs on the same clk.

Decomposition:
- Shared include/package clk_tick_defs:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2;
  - WRAP_W=8 and WRAP_SAT=8'd255.
- One natural sub-module: edge_rise_det. It holds the optional synchroniser plus ck_d, and outputs tick; it takes the same clk/rst and the CLK_TICK_SYNC_EN macro.

Test Plan:
- rst=1 for 2 cycles with ck_in=1, then rst=0 and ck_in held 1 -> count=0, tc_pulse=0, no tick.
- ck_in toggling every 5 clk (period 10), start pulsed 1 cycle -> count steps 0..9, one increment per 10 clk. The 10th tick gives count=0 and a single-cycle tc_pulse; wrap_cnt=1.
- stop asserted in the same cycle as a tick at count=4 -> count stays 4, running=0. Start 30 cycles later -> resumes from 4; the rises during PAUSE are not counted.
- clear asserted together with start and stop while in RUN at count=7 -> next cycle state IDLE, count=0, wrap_cnt=0, running=0.
- Run for 260 wraps (CNT_MAX=1 to shorten) -> wrap_cnt saturates at 255 and stays there; tc_pulse still fires every wrap.
- CLK_TICK_SYNC_EN defined -> count increments 3 cycles after the ck_in rise instead of 1; all other results identical.
